// File: rtl/intersection_phase_sched.sv
// Round-robin phase scheduler for a four-phase intersection.
// Each grant runs green -> yellow/flash -> all-red with min/max green limits.
module intersection_phase_sched #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int PED_TIME    = 6,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
    input  logic       ped_req,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       pedestrian_green,
    output logic       up_yellow,
    output logic       down_yellow,
    output logic       turn_yellow,
    output logic       ped_flash,
    output logic [1:0] active_phase,
    output logic       idle
);

    localparam int T1   = (MAX_GREEN > PED_TIME) ? MAX_GREEN : PED_TIME;
    localparam int T2   = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          clr_q, clr_d;
    logic [3:0]    pend_q, pend_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    phase_q, phase_d;

    logic [3:0] req, cand, own, others;
    logic [1:0] sel, idx;
    logic       found, cleared, veh_exit, ped_exit, green_exit;

    assign req    = {ped_req, turn_req, down_req, up_req};
    assign cand   = pend_q | req;
    assign own    = 4'b0001 << phase_q;
    assign others = cand & ~own;

    assign cleared  = clr_q || (timer_q == TW'(ALLRED_TIME - 1));
    assign ped_exit = (timer_q == TW'(PED_TIME - 1));
    assign veh_exit = (timer_q >= TW'(MIN_GREEN - 1)) &&
                      ((|others) || !req[phase_q] ||
                       (timer_q == TW'(MAX_GREEN - 1)));
    assign green_exit = (phase_q == 2'd3) ? ped_exit : veh_exit;

    // First candidate at or after the round-robin pointer, wrapping.
    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        clr_d   = clr_q;
        rr_d    = rr_q;
        phase_d = phase_q;
        pend_d  = pend_q | (req & ~((state_q == S_GREEN) ? own : 4'b0000));
        unique case (state_q)
            S_ALLRED: begin
                if (cleared && found) begin
                    state_d      = S_GREEN;
                    timer_d      = '0;
                    phase_d      = sel;
                    rr_d         = sel + 2'd1;
                    pend_d[sel]  = 1'b0;
                end else if (cleared) begin
                    clr_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GREEN: begin
                if (green_exit) begin
                    state_d = S_YELLOW;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_YELLOW: begin
                if (timer_q == TW'(YELLOW_TIME - 1)) begin
                    state_d = S_ALLRED;
                    timer_d = '0;
                    clr_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_ALLRED;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ALLRED;
            timer_q <= '0;
            clr_q   <= 1'b1;
            pend_q  <= 4'b0000;
            rr_q    <= 2'd0;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            clr_q   <= clr_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            phase_q <= phase_d;
        end
    end

    assign up_green         = (state_q == S_GREEN)  && (phase_q == 2'd0);
    assign down_green       = (state_q == S_GREEN)  && (phase_q == 2'd1);
    assign turn_green       = (state_q == S_GREEN)  && (phase_q == 2'd2);
    assign pedestrian_green = (state_q == S_GREEN)  && (phase_q == 2'd3);
    assign up_yellow        = (state_q == S_YELLOW) && (phase_q == 2'd0);
    assign down_yellow      = (state_q == S_YELLOW) && (phase_q == 2'd1);
    assign turn_yellow      = (state_q == S_YELLOW) && (phase_q == 2'd2);
    assign ped_flash        = (state_q == S_YELLOW) && (phase_q == 2'd3);
    assign active_phase     = phase_q;
    assign idle = (state_q == S_ALLRED) && clr_q && (pend_q == 4'b0000);

endmodule
